lut_neuron_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed combinational LUT neuron.
- Holds a runtime-loadable truth table of 2^(IN_CH*IN_BITS) entries, each OUT_BITS wide.
- Maps packed quantised activations to one quantised output through a 2-stage valid/ready pipeline.
- Sits between neuron layers of a generated LogicNets network; the table is loaded by the host config bus instead of being baked in as a case ROM.

---
 rtl/lut_neuron_pkg.sv | 19 +
 rtl/lut_table_ram.sv | 35 +++
 rtl/lut_neuron_pipe.sv | 111 +++++++++++
 tb/tb_lut_neuron_pipe.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_neuron_pkg.sv
// Shared types and defaults for the LUT neuron family; the layer generator
// imports the same default quantisation widths.
package lut_neuron_pkg;

  localparam int DEF_IN_CH    = 4;
  localparam int DEF_IN_BITS  = 2;
  localparam int DEF_OUT_BITS = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Number of truth-table entries for a neuron with the given fan-in.
  function automatic int table_depth(input int in_ch, input int in_bits);
    return 1 << (in_ch * in_bits);
  endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Truth-table storage: one write port, one synchronous read port with
// read enable. A read and a write to the same address return the old data.
module lut_table_ram #(
  parameter int AW = 8,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array is deliberately left out of reset so it maps onto
  // distributed RAM; the post-reset clear sweep gives it defined contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: non-blocking writes mean a same-edge read samples the value from
  // before this edge's write, which is exactly read-before-write behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lut_neuron_pipe.sv
// Pipelined LUT neuron: a runtime-loadable truth table looked up through a
// 2-stage valid/ready pipeline, cleared to INIT_VAL after every reset.
module lut_neuron_pipe
  import lut_neuron_pkg::*;
#(
  parameter int                  IN_CH    = DEF_IN_CH,
  parameter int                  IN_BITS  = DEF_IN_BITS,
  parameter int                  OUT_BITS = DEF_OUT_BITS,
  parameter logic [OUT_BITS-1:0] INIT_VAL = '0,
  localparam int                 AW       = IN_CH * IN_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_wdata,
  output logic                cfg_busy
);

  localparam int            DEPTH = table_depth(IN_CH, IN_BITS);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  state_t              state, state_nxt;
  logic [AW-1:0]       cnt, cnt_nxt;
  logic                run;
  logic                ram_we;
  logic [AW-1:0]       ram_waddr;
  logic [OUT_BITS-1:0] ram_wdata;

  logic          adv;
  logic          s1_valid;
  logic [AW-1:0] s1_addr;
  logic          s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The sweep owns the RAM write port while clearing; host writes are dropped.
  // NOTE: every output of this block is assigned a default first so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    run       = 1'b0;
    cfg_busy  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = cfg_addr;
    ram_wdata = cfg_wdata;
    unique case (state)
      CLEAR: begin
        cfg_busy  = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = cnt;
        ram_wdata = INIT_VAL;
        cnt_nxt   = cnt + AW'(1);
        if (cnt == LAST) state_nxt = RUN;
      end
      RUN: begin
        run    = 1'b1;
        ram_we = cfg_we;
      end
    endcase
  end

  assign adv      = !s2_valid || out_ready;
  assign in_ready = run && adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s2_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid && in_ready;
      s1_addr  <= in_data;
      s2_valid <= s1_valid;
    end
  end

  // The RAM output register is stage 2's data; gating its read with adv keeps
  // a stalled beat frozen even if the host rewrites that entry meanwhile.
  lut_table_ram #(
    .AW (AW),
    .DW (OUT_BITS)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (adv),
    .raddr (s1_addr),
    .rdata (out_data)
  );

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_lut_neuron_pipe.sv
// Self-checking bench for lut_neuron_pipe: table-driven lookups, a scoreboard
// driven by a plain array model, and hand-written stall/collision/reset cases.
module tb_lut_neuron_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       cfg_we;
  logic [7:0] cfg_addr;
  logic [1:0] cfg_wdata;
  logic       cfg_busy;

  int checks = 0;
  int errors = 0;

  logic [1:0] model [256];
  logic [1:0] exp_q [$];

  typedef struct {
    logic [7:0] waddr;
    logic [1:0] wdata;
    logic [7:0] raddr;
    logic [1:0] exp;
  } vec_t;

  vec_t vecs [8];

  lut_neuron_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_busy  (cfg_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Neuron reference: quantised mean of the four 2-bit activations.
  function automatic logic [1:0] golden(input logic [7:0] a);
    int s;
    s = int'(a[1:0]) + int'(a[3:2]) + int'(a[5:4]) + int'(a[7:6]);
    s = s / 4;
    if (s > 3) s = 3;
    return 2'(s);
  endfunction

  task automatic cfg_write(input logic [7:0] a, input logic [1:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
    model[a]  = d;
  endtask

  task automatic wait_sweep(input string tag);
    int n = 0;
    int rdy_seen = 0;
    out_ready = 1'b1;
    #1;
    while (cfg_busy === 1'b1 && n < 1000) begin
      if (in_ready !== 1'b0) rdy_seen++;
      n++;
      tick();
    end
    check({tag, " sweep cycles"}, n, 256);
    check({tag, " in_ready during sweep"}, rdy_seen, 0);
    check({tag, " cfg_busy after sweep"}, cfg_busy, 0);
    check({tag, " in_ready after sweep"}, in_ready, 1);
    for (int i = 0; i < 256; i++) model[i] = 2'b00;
  endtask

  task automatic lookup(input logic [7:0] a, output logic [1:0] d, output int lat);
    int w = 0;
    in_data   = a;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    while (in_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    if (w == 50) begin
      checks++;
      errors++;
      $display("FAIL lookup accept timeout: in_ready stuck at %b", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    d = out_data;
    tick();
  endtask

  task automatic stream(input bit seq, input int nb, input int vpct, input int rpct,
                        input string tag, output int cyc);
    int sent = 0;
    int got = 0;
    logic [1:0] e;
    cyc = 0;
    exp_q.delete();
    while ((sent < nb || exp_q.size() > 0) && cyc < 20000) begin
      in_valid  = (sent < nb) && ($urandom_range(99) < vpct);
      in_data   = seq ? 8'(sent) : 8'($urandom);
      out_ready = ($urandom_range(99) < rpct);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s spurious beat: got %0h expected none", tag, out_data);
        end else begin
          e = exp_q.pop_front();
          check(tag, out_data, e);
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model[in_data]);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, " beat count"}, got, nb);
  endtask

  initial begin
    logic [1:0] d;
    int lat, cyc, acc, idx, stable_err, got;
    logic [1:0] held;
    bit have;
    logic [7:0] beats [3];
    logic [1:0] e;

    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    #2;
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset in_ready", in_ready, 0);
    check("reset cfg_busy", cfg_busy, 1);
    tick();
    rst = 1'b0;
    wait_sweep("initial");

    lookup(8'hFF, d, lat);
    check("post-clear lookup FF", d, 2'b00);

    vecs[0] = '{8'hC0, 2'b01, 8'hC0, 2'b01};
    vecs[1] = '{8'hFF, 2'b11, 8'hFF, 2'b11};
    vecs[2] = '{8'h00, 2'b10, 8'h00, 2'b10};
    vecs[3] = '{8'h01, 2'b11, 8'h00, 2'b10};
    vecs[4] = '{8'h80, 2'b01, 8'h00, 2'b10};
    vecs[5] = '{8'hFE, 2'b10, 8'hFF, 2'b11};
    vecs[6] = '{8'hC0, 2'b10, 8'hC0, 2'b10};
    vecs[7] = '{8'h3C, 2'b01, 8'hC3, 2'b00};
    for (int i = 0; i < 8; i++) begin
      cfg_write(vecs[i].waddr, vecs[i].wdata);
      lookup(vecs[i].raddr, d, lat);
      check($sformatf("vec%0d data", i), d, vecs[i].exp);
      check($sformatf("vec%0d latency", i), lat, 2);
    end

    for (int a = 0; a < 256; a++) cfg_write(8'(a), golden(8'(a)));
    stream(1'b1, 256, 100, 100, "golden sweep", cyc);
    check("golden sweep back-to-back cycles", cyc, 258);

    // Backpressure: three beats offered against a stalled sink.
    beats[0] = 8'h55; beats[1] = 8'hAA; beats[2] = 8'hFF;
    exp_q.delete();
    out_ready = 1'b0; idx = 0; have = 1'b0; stable_err = 0; held = '0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 3);
      in_data  = beats[(idx < 3) ? idx : 0];
      if (c == 3) begin
        cfg_we = 1'b1; cfg_addr = 8'h55; cfg_wdata = 2'b00;
      end
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model[in_data]);
        idx++;
      end
      if (out_valid) begin
        if (!have) begin
          held = out_data;
          have = 1'b1;
        end else if (out_data !== held) begin
          stable_err++;
        end
      end
      tick();
      if (cfg_we) begin
        cfg_we = 1'b0;
        model[8'h55] = 2'b00;
      end
    end
    check("stall accepted beats", idx, 2);
    check("stall held value", held, 2'b01);
    check("stall out_data unstable cycles", stable_err, 0);
    check("stall held after cfg write", out_data, 2'b01);
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      in_valid  = (idx < 3);
      in_data   = beats[(idx < 3) ? idx : 0];
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
        check($sformatf("drain beat %0d", got), out_data, e);
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model[in_data]);
        idx++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("drain beat count", got, 3);
    check("drain leftover", exp_q.size(), 0);

    // Same-edge cfg write and stage-2 read of one address.
    cfg_write(8'h04, 2'b01);
    in_data = 8'h04; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 8'h04; cfg_wdata = 2'b10;
    tick();
    cfg_we = 1'b0;
    model[8'h04] = 2'b10;
    check("collision out_valid", out_valid, 1);
    check("collision old value", out_data, 2'b01);
    tick();
    lookup(8'h04, d, lat);
    check("collision next lookup", d, 2'b10);

    for (int a = 0; a < 256; a++) cfg_write(8'(a), 2'($urandom));
    stream(1'b0, 600, 70, 60, "random stream", cyc);

    // Reset with two beats in flight.
    cfg_write(8'h33, 2'b11);
    in_data = 8'h33; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    check("pre-reset out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset cfg_busy", cfg_busy, 1);
    check("async reset in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    wait_sweep("mid-op reset");
    check("mid-op reset no stale beat", out_valid, 0);
    lookup(8'h33, d, lat);
    check("re-cleared entry 33", d, 2'b00);
    lookup(8'h04, d, lat);
    check("re-cleared entry 04", d, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
